// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared HDMI codes and timing constants for the data-island scheduler.
// Period lengths are fixed by the TMDS framing.
package hdmi_island_scheduler_pkg;

  // 3-bit island/video sequencing codes shared with the HDMI top.
  typedef enum logic [2:0] {
    CtlControlData     = 3'b000,
    CtlVideoPreamble   = 3'b001,
    CtlVideoGuard      = 3'b010,
    CtlVideoData       = 3'b011,
    CtlIslandPreamble  = 3'b100,
    CtlIslandPreGuard  = 3'b101,
    CtlIslandPostGuard = 3'b110,
    CtlDataIsland      = 3'b111
  } ctl_code_e;

  localparam int unsigned PreambleLen = 8;
  localparam int unsigned GuardLen    = 2;
  localparam int unsigned PacketLen   = 32;

  typedef enum logic [2:0] {
    StCtrl,
    StPre,
    StPreGuard,
    StPkt,
    StPostGuard,
    StGap
  } island_state_e;

  function automatic ctl_code_e state_to_ctl(island_state_e st);
    ctl_code_e code;
    unique case (st)
      StPre:       code = CtlIslandPreamble;
      StPreGuard:  code = CtlIslandPreGuard;
      StPkt:       code = CtlDataIsland;
      StPostGuard: code = CtlIslandPostGuard;
      default:     code = CtlControlData;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hdmi_island_scheduler_arbiter.sv
// Packet-slot arbiter: requester 0 has strict priority, 1..NReq-1 share slots
// round-robin. The pointer only moves when a round-robin requester is granted.
module hdmi_island_scheduler_arbiter #(
  parameter int unsigned NReq = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NReq-1:0] req_i,
  input  logic            advance_i,
  output logic [NReq-1:0] gnt_o
);

  localparam int          NR   = int'(NReq);
  localparam int unsigned PtrW = (NReq > 2) ? $clog2(NReq) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int              win;
  int              nxt;

  always_comb begin
    found = 1'b0;
    win   = 0;
    // First pass: at/after pointer; second pass wraps to the low indices.
    for (int i = 1; i < NR; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        win   = i;
      end
    end
    for (int i = 1; i < NR; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        win   = i;
      end
    end

    gnt_o = '0;
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
    end else begin
      for (int i = 1; i < NR; i++) begin
        gnt_o[i] = found && (win == i);
      end
    end

    nxt   = (win + 1 >= NR) ? 1 : win + 1;
    ptr_d = ptr_q;
    if (advance_i && !req_i[0] && found) begin
      ptr_d = PtrW'(nxt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= PtrW'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Data-island scheduler: measures each blanking period and packs packet slots
// into the next one without running into the video preamble.
module hdmi_island_scheduler
  import hdmi_island_scheduler_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned MAX_PKTS     = 18,
  parameter int unsigned START_OFFSET = 10,
  parameter int unsigned VID_MARGIN   = 12,
  parameter int unsigned ISLAND_GAP   = 4,
  parameter int unsigned CW           = 12
) (
  input  logic            i_pixclk,
  input  logic            i_reset_n,
  input  logic            i_blank,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [2:0]      o_ctl_state,
  output logic            o_island,
  output logic [4:0]      o_slot_phase,
  output logic [4:0]      o_pkt_count,
  output logic [CW-1:0]   o_budget,
  output logic            o_abort
);

  localparam logic [31:0] StartNeed = 32'(PreambleLen + 2 * GuardLen + PacketLen + VID_MARGIN);
  localparam logic [31:0] SlotNeed  = 32'(PacketLen + GuardLen + VID_MARGIN);
  localparam logic [CW-1:0] ElapsedMax = '1;

  island_state_e   state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      pkt_q, pkt_d;
  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      ctl_q, ctl_d;
  logic            island_q, island_d;
  logic [4:0]      phase_q, phase_d;
  logic            abort_q, abort_d;
  logic [CW-1:0]   elapsed_q, elapsed_d;
  logic [CW-1:0]   budget_q, budget_d;
  logic            blank_prev_q, blank_prev_d;
  logic            meas_ok_q, meas_ok_d;

  logic            blank_rise, blank_fall;
  logic [31:0]     el_w, bud_w;
  logic            start_ok, slot_ok, adv;
  logic [NREQ-1:0] arb_gnt;

  hdmi_island_scheduler_arbiter #(
    .NReq(NREQ)
  ) u_arbiter (
    .clk_i    (i_pixclk),
    .rst_ni   (i_reset_n),
    .req_i    (req_q),
    .advance_i(adv),
    .gnt_o    (arb_gnt)
  );

  // Blank measurement. A blank partly cut by reset never becomes a budget.
  always_comb begin
    blank_rise   = i_blank && !blank_prev_q;
    blank_fall   = !i_blank && blank_prev_q;
    blank_prev_d = i_blank;
    meas_ok_d    = meas_ok_q || blank_rise;
    elapsed_d    = elapsed_q;
    if (blank_rise) begin
      elapsed_d = '0;
    end else if (i_blank && (elapsed_q != ElapsedMax)) begin
      elapsed_d = elapsed_q + CW'(1);
    end
    budget_d = budget_q;
    if (blank_fall && meas_ok_q) begin
      budget_d = (elapsed_q == ElapsedMax) ? elapsed_q : elapsed_q + CW'(1);
    end
  end

  // Fit checks use the elapsed count of the cycle the new state would occupy.
  always_comb begin
    el_w     = 32'(elapsed_d);
    bud_w    = 32'(budget_q);
    start_ok = i_blank && (el_w >= START_OFFSET) && (|req_q) && (el_w + StartNeed <= bud_w);
    slot_ok  = (|req_q) && (32'(pkt_q) < MAX_PKTS) && (el_w + SlotNeed <= bud_w);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    gnt_d   = '0;
    abort_d = 1'b0;
    adv     = 1'b0;

    unique case (state_q)
      StCtrl: begin
        if (start_ok) begin
          state_d = StPre;
          cnt_d   = '0;
          pkt_d   = '0;
        end
      end
      StPre: begin
        if (!i_blank) begin
          state_d = StCtrl;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == 5'(PreambleLen - 1)) begin
          state_d = StPreGuard;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StPreGuard, StPkt: begin
        if (!i_blank) begin
          state_d = StCtrl;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if ((state_q == StPreGuard && cnt_q == 5'(GuardLen - 1)) ||
                     (state_q == StPkt && cnt_q == 5'(PacketLen - 1))) begin
          cnt_d = '0;
          if (slot_ok) begin
            state_d = StPkt;
            pkt_d   = pkt_q + 5'd1;
            gnt_d   = arb_gnt;
            adv     = 1'b1;
          end else begin
            state_d = StPostGuard;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StPostGuard: begin
        if (!i_blank) begin
          state_d = StCtrl;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == 5'(GuardLen - 1)) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StGap: begin
        if (!i_blank) begin
          state_d = StCtrl;
          cnt_d   = '0;
        end else if (cnt_q == 5'(ISLAND_GAP - 1)) begin
          cnt_d = '0;
          if (start_ok) begin
            state_d = StPre;
            pkt_d   = '0;
          end else begin
            state_d = StCtrl;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = StCtrl;
        cnt_d   = '0;
      end
    endcase

    ctl_d    = state_to_ctl(state_d);
    island_d = (state_d == StPkt);
    phase_d  = (state_d == StPkt) ? cnt_d : '0;
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      state_q      <= StCtrl;
      cnt_q        <= '0;
      pkt_q        <= '0;
      req_q        <= '0;
      gnt_q        <= '0;
      ctl_q        <= CtlControlData;
      island_q     <= 1'b0;
      phase_q      <= '0;
      abort_q      <= 1'b0;
      elapsed_q    <= '0;
      budget_q     <= '0;
      blank_prev_q <= 1'b1;
      meas_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pkt_q        <= pkt_d;
      req_q        <= i_req;
      gnt_q        <= gnt_d;
      ctl_q        <= ctl_d;
      island_q     <= island_d;
      phase_q      <= phase_d;
      abort_q      <= abort_d;
      elapsed_q    <= elapsed_d;
      budget_q     <= budget_d;
      blank_prev_q <= blank_prev_d;
      meas_ok_q    <= meas_ok_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_ctl_state  = ctl_q;
  assign o_island     = island_q;
  assign o_slot_phase = phase_q;
  assign o_pkt_count  = pkt_q;
  assign o_budget     = budget_q;
  assign o_abort      = abort_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for the HDMI data-island scheduler: blank measurement, slot
// timing, arbitration order, packet limit, abort and reset recovery.
module tb_hdmi_island_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blank;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [2:0]  ctl;
  logic        island;
  logic [4:0]  phase;
  logic [4:0]  pkt;
  logic [11:0] budget;
  logic        abort;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_order [6];

  always #5 clk = ~clk;

  hdmi_island_scheduler dut (
    .i_pixclk    (clk),
    .i_reset_n   (rst_n),
    .i_blank     (blank),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_ctl_state (ctl),
    .o_island    (island),
    .o_slot_phase(phase),
    .o_pkt_count (pkt),
    .o_budget    (budget),
    .o_abort     (abort)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    blank = 1'b0;
    repeat (n) tick();
  endtask

  task automatic measure_blank(input int len);
    blank = 1'b1;
    repeat (len) tick();
    blank = 1'b0;
    tick();
  endtask

  // Expected sequencing for a 280-cycle budget with a single requester.
  function automatic logic [2:0] exp_ctl7(input int e);
    if (e >= 10 && e <= 17) return 3'b100;
    if (e >= 18 && e <= 19) return 3'b101;
    if (e >= 20 && e <= 243) return 3'b111;
    if (e >= 244 && e <= 245) return 3'b110;
    return 3'b000;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    blank = 1'b0;
    req   = 4'b0000;
    repeat (3) tick();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++;
    if (ctl !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", ctl); end
    checks++;
    if (island !== 1'b0) begin errors++; $display("FAIL reset_island: got %b expected 0", island); end
    checks++;
    if (phase !== 5'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++;
    if (pkt !== 5'd0) begin errors++; $display("FAIL reset_pkt: got %0d expected 0", pkt); end
    checks++;
    if (budget !== 12'd0) begin errors++; $display("FAIL reset_budget: got %0d expected 0", budget); end
    checks++;
    if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_first_blank();
    req   = 4'b0001;
    blank = 1'b1;
    for (int e = 0; e < 280; e++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || ctl !== 3'b000) begin
        errors++;
        $display("FAIL first_blank_idle: e=%0d got gnt=%b ctl=%b expected gnt=0000 ctl=000",
                 e, gnt, ctl);
      end
    end
    blank = 1'b0;
    tick();
    checks++;
    if (budget !== 12'd280) begin errors++; $display("FAIL first_budget: got %0d expected 280", budget); end
    idle(20);
  endtask

  task automatic test_seven_pkts();
    logic [3:0] eg;
    logic [4:0] ep;
    logic       ei;
    req   = 4'b0001;
    blank = 1'b1;
    for (int e = 0; e < 280; e++) begin
      tick();
      ei = (e >= 20 && e <= 243);
      ep = ei ? 5'((e - 20) % 32) : 5'd0;
      eg = (ei && e <= 212 && ((e - 20) % 32) == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if (ctl !== exp_ctl7(e)) begin
        errors++; $display("FAIL seven_ctl: e=%0d got %b expected %b", e, ctl, exp_ctl7(e));
      end
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL seven_gnt: e=%0d got %b expected %b", e, gnt, eg); end
      checks++;
      if (island !== ei || phase !== ep) begin
        errors++;
        $display("FAIL seven_slot: e=%0d got island=%b phase=%0d expected island=%b phase=%0d",
                 e, island, phase, ei, ep);
      end
    end
    blank = 1'b0;
    tick();
    checks++;
    if (pkt !== 5'd7) begin errors++; $display("FAIL seven_pkt_count: got %0d expected 7", pkt); end
    checks++;
    if (budget !== 12'd280) begin errors++; $display("FAIL seven_budget: got %0d expected 280", budget); end
    idle(20);
  endtask

  task automatic test_round_robin();
    int slot;
    req = 4'b0000;
    measure_blank(1000);
    checks++;
    if (budget !== 12'd1000) begin errors++; $display("FAIL rr_budget: got %0d expected 1000", budget); end
    idle(20);
    exp_order[0] = 4'b0010;
    exp_order[1] = 4'b0100;
    exp_order[2] = 4'b1000;
    exp_order[3] = 4'b0001;
    exp_order[4] = 4'b0010;
    exp_order[5] = 4'b0100;
    slot  = 0;
    req   = 4'b1110;
    blank = 1'b1;
    for (int e = 0; e < 2000; e++) begin
      tick();
      if (e == 90) req = 4'b1111;
      if (gnt !== 4'b0000 && slot < 6) begin
        checks++;
        if (gnt !== exp_order[slot] || e != 20 + 32 * slot) begin
          errors++;
          $display("FAIL rr_grant: slot=%0d got gnt=%b at e=%0d expected gnt=%b at e=%0d",
                   slot, gnt, e, exp_order[slot], 20 + 32 * slot);
        end
        if (gnt[0]) req = 4'b1110;
        slot++;
      end
    end
    checks++;
    if (slot != 6) begin errors++; $display("FAIL rr_grant_count: got %0d expected 6", slot); end
    blank = 1'b0;
    tick();
    checks++;
    if (budget !== 12'd2000) begin errors++; $display("FAIL rr_budget2: got %0d expected 2000", budget); end
    idle(20);
  endtask

  task automatic test_max_packets();
    int n;
    n     = 0;
    req   = 4'b1111;
    blank = 1'b1;
    for (int e = 0; e < 700; e++) begin
      tick();
      if (e < 602 && gnt !== 4'b0000) begin
        checks++;
        if (gnt !== 4'b0001 || e != 20 + 32 * n) begin
          errors++;
          $display("FAIL max_grant: n=%0d got gnt=%b at e=%0d expected gnt=0001 at e=%0d",
                   n, gnt, e, 20 + 32 * n);
        end
        n++;
      end
      if (e == 595) begin
        checks++;
        if (pkt !== 5'd18) begin errors++; $display("FAIL max_pkt_count: got %0d expected 18", pkt); end
      end
      if (e == 596 || e == 597) begin
        checks++;
        if (ctl !== 3'b110) begin errors++; $display("FAIL max_postguard: e=%0d got %b expected 110", e, ctl); end
      end
      if (e >= 598 && e <= 601) begin
        checks++;
        if (ctl !== 3'b000) begin errors++; $display("FAIL max_gap: e=%0d got %b expected 000", e, ctl); end
      end
      if (e == 602) begin
        checks++;
        if (ctl !== 3'b100 || pkt !== 5'd0) begin
          errors++;
          $display("FAIL max_restart: got ctl=%b pkt=%0d expected ctl=100 pkt=0", ctl, pkt);
        end
      end
    end
    checks++;
    if (n != 18) begin errors++; $display("FAIL max_total: got %0d expected 18", n); end
    blank = 1'b0;
    tick();
    checks++;
    if (abort !== 1'b1) begin errors++; $display("FAIL max_abort: got %b expected 1", abort); end
    req = 4'b0000;
    idle(20);
    measure_blank(280);
    checks++;
    if (budget !== 12'd280) begin errors++; $display("FAIL max_budget: got %0d expected 280", budget); end
    idle(20);
  endtask

  task automatic test_abort();
    req   = 4'b0001;
    blank = 1'b1;
    for (int e = 0; e < 100; e++) tick();
    checks++;
    if (ctl !== 3'b111 || island !== 1'b1 || phase !== 5'd15) begin
      errors++;
      $display("FAIL abort_pre: got ctl=%b island=%b phase=%0d expected ctl=111 island=1 phase=15",
               ctl, island, phase);
    end
    blank = 1'b0;
    tick();
    checks++;
    if (abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", abort); end
    checks++;
    if (ctl !== 3'b000 || gnt !== 4'b0000 || island !== 1'b0 || phase !== 5'd0) begin
      errors++;
      $display("FAIL abort_outputs: got ctl=%b gnt=%b island=%b phase=%0d expected all 0",
               ctl, gnt, island, phase);
    end
    checks++;
    if (budget !== 12'd100) begin errors++; $display("FAIL abort_budget: got %0d expected 100", budget); end
    tick();
    checks++;
    if (abort !== 1'b0) begin errors++; $display("FAIL abort_width: got %b expected 0", abort); end
    idle(20);
  endtask

  task automatic test_reset_mid();
    req   = 4'b0001;
    blank = 1'b1;
    for (int e = 0; e < 30; e++) tick();
    checks++;
    if (ctl !== 3'b111) begin errors++; $display("FAIL rmid_in_pkt: got %b expected 111", ctl); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || ctl !== 3'b000 || island !== 1'b0 || phase !== 5'd0 ||
        pkt !== 5'd0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs: got gnt=%b ctl=%b island=%b phase=%0d pkt=%0d abort=%b expected 0",
               gnt, ctl, island, phase, pkt, abort);
    end
    checks++;
    if (budget !== 12'd0) begin errors++; $display("FAIL rmid_budget: got %0d expected 0", budget); end
    rst_n = 1'b1;
    for (int e = 0; e < 200; e++) begin
      tick();
      checks++;
      if (ctl !== 3'b000 || gnt !== 4'b0000) begin
        errors++; $display("FAIL rmid_rest: e=%0d got ctl=%b gnt=%b expected 000/0000", e, ctl, gnt);
      end
    end
    blank = 1'b0;
    tick();
    checks++;
    if (budget !== 12'd0) begin errors++; $display("FAIL rmid_partial: got %0d expected 0", budget); end
    idle(20);
    blank = 1'b1;
    for (int e = 0; e < 280; e++) begin
      tick();
      checks++;
      if (ctl !== 3'b000 || gnt !== 4'b0000) begin
        errors++; $display("FAIL rmid_next: e=%0d got ctl=%b gnt=%b expected 000/0000", e, ctl, gnt);
      end
    end
    blank = 1'b0;
    tick();
    checks++;
    if (budget !== 12'd280) begin errors++; $display("FAIL rmid_remeasure: got %0d expected 280", budget); end
  endtask

  initial begin
    test_reset();
    test_first_blank();
    test_seven_pkts();
    test_round_robin();
    test_max_packets();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_island_scheduler.md
Name: hdmi_island_scheduler

Overview:
Schedules HDMI data islands inside horizontal/vertical blanking and shares the packet slots among NREQ packet sources (audio sample, ACR, AVI infoframe, audio infoframe). Measures each blanking period and uses the measurement as the budget for the next blanking period, so an island never overruns into the video preamble. Drives island sequencing codes and per-slot grants to the packet encoder and TMDS guard/preamble muxing, in the pixel-clock domain.

Parameters:
NREQ, 4, number of packet requesters; index 0 is strict-highest priority, 1..NREQ-1 round-robin
MAX_PKTS, 18, max packets per island
START_OFFSET, 10, blank cycles elapsed before the first preamble may start
VID_MARGIN, 12, cycles reserved at end of blank (video preamble 8 + guard 2 + slack 2)
ISLAND_GAP, 4, minimum control cycles between postguard end and the next preamble
CW, 12, width of blank counter/budget (saturating)

Ports:
i_pixclk  in  1  pixel clock
i_reset_n  in  1  synchronous reset, active low
i_blank  in  1  blanking, same timing as encoder blank input
i_req  in  NREQ  packet request per source, level, held until granted
o_gnt  out  NREQ  one-hot grant, 1-cycle pulse in phase 0 of the granted slot
o_ctl_state  out  3  island sequencing code: controlData/dataIslandPreamble/dataIslandPreGuard/dataIsland/dataIslandPostGuard
o_island  out  1  high during data-island packet slots only
o_slot_phase  out  5  0..31 within the current packet slot, 0 otherwise
o_pkt_count  out  5  packets issued in current island
o_budget  out  CW  last measured blank length
o_abort  out  1  1-cycle pulse: blank ended while island in progress

Behaviour:
- One clock, i_pixclk; reset is synchronous, active-low (i_reset_n), sampled on i_pixclk rising edge.
- Reset: all outputs 0, o_ctl_state=controlData, budget=0 (no islands until one blank measured), RR pointer=1, elapsed=0.
- elapsed: clears on the i_blank 0->1 edge, increments each blank cycle, saturates at 2^CW-1. On the 1->0 edge, budget<=elapsed+1.
- States: CTRL, PRE(8 cycles), PREGUARD(2), PKT(32 per slot), POSTGUARD(2), GAP(ISLAND_GAP). o_ctl_state mirrors state, GAP/CTRL -> controlData.
- CTRL->PRE when i_blank, elapsed>=START_OFFSET, |i_req, gap satisfied, and elapsed+12+32+VID_MARGIN <= budget.
- Slot decision (last PREGUARD cycle or phase 31): next slot issued if |i_req, pkt_count<MAX_PKTS, elapsed+1+32+2+VID_MARGIN <= budget; otherwise POSTGUARD. If PREGUARD decision fails (request withdrawn), go to POSTGUARD with pkt_count=0.
- Arbitration at decision cycle on registered i_req: req[0] wins; else first set bit at/after RR pointer among 1..NREQ-1; pointer advances past the winner. o_gnt is registered, asserted in phase 0.
- Requester must drop req the cycle after seeing gnt unless it has another packet; a req sampled high in phase 0 of its own grant is not double-counted (decision is only at phase 31).
- POSTGUARD->GAP->CTRL; pkt_count clears on PRE entry.
- i_blank falls in PRE..POSTGUARD: o_abort pulses, state->CTRL, o_gnt/o_island/phase cleared next cycle; budget still updated.
- i_blank low in CTRL: no island starts. Simultaneous blank rise and reset: reset wins.

Decomposition:
- Shared package hdmi_pkg: 3-bit island/video state codes (controlData=000 .. dataIsland=111) shared with the hdmi top, preamble/guard lengths (8, 2), packet length 32.
- Sub-module hdmi_rr_arbiter (NREQ-wide, priority index 0 + round-robin rest, pointer register) is natural; the FSM and counters stay in the top.

Test Plan:
- Reset, blank 280 cycles, req=0001 -> no gnt in first blank; o_budget=280 after blank falls.
- Second 280-cycle blank, req[0] held -> PRE at elapsed 10-17, PREGUARD 18-19, gnt[0] at elapsed 20,52,...,212 (7 pkts), POSTGUARD 244-245, o_pkt_count=7.
- Budget 1000, req=1110 held -> grant order 1,2,3,1,...; raise req[0] during slot 3 -> slot 4 grants 0.
- Budget 2000, req=1111 held -> exactly 18 packets, postguard, 4 GAP cycles, new PRE at next eligible cycle.
- Budget 280 then blank ends after 100 cycles mid-packet -> o_abort 1 cycle, o_ctl_state=000, o_gnt=0, o_budget=100.
- i_reset_n low mid-PKT for 1 cycle -> next edge all outputs 0, budget 0, no island in following blank.
